logic_unit_pipe: RTL and testbench

- Parametrised, pipelined N-bit bitwise logic unit: BUF, NOT, AND, OR, XOR, NAND, NOR and XNOR on WIDTH-bit operands, selected per transaction.
- Valid/ready handshakes on input and output; full throughput of one result per cycle.
- Optional accumulate mode chains results through an internal register, e.g. a running XOR or AND mask across a stream.
- Status flags (zero, all-ones, parity) are produced alongside each result. Shared logic-op engine for datapath and test blocks.

---
 rtl/logic_unit_pipe_if.sv | 59 +++++
 rtl/logic_unit_pipe.sv | 155 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe: an input channel (operands, op, accumulator
// controls) and an output channel (result, flags), plus the live accumulator value.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             zero;
  logic             all_ones;
  logic             parity;
  logic [WIDTH-1:0] acc_q;

  // Unit side
  modport slave (
    input  in_valid,
    input  op,
    input  acc_en,
    input  acc_clr,
    input  A,
    input  B,
    input  out_ready,
    output in_ready,
    output out_valid,
    output C,
    output zero,
    output all_ones,
    output parity,
    output acc_q
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output op,
    output acc_en,
    output acc_clr,
    output A,
    output B,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  C,
    input  zero,
    input  all_ones,
    input  parity,
    input  acc_q
  );

endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready flow control, an optional
// running accumulator and registered zero/all-ones/parity flags.
module logic_unit_pipe #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OpBuf  = 3'b000,
    OpNot  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpNand = 3'b101,
    OpNor  = 3'b110,
    OpXnor = 3'b111
  } op_e;

  // Single op engine, shared by the S2 datapath and the accumulator update.
  function automatic logic [WIDTH-1:0] logic_op(input op_e             op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    unique case (op)
      OpBuf:   r = a;
      OpNot:   r = ~a;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpNand:  r = ~(a & b);
      OpNor:   r = ~(a | b);
      OpXnor:  r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  // Stage 1: captured op and effective operands
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;
  logic             all_ones_q, all_ones_d;
  logic             parity_q, parity_d;

  logic [WIDTH-1:0] accum_q, accum_d;

  logic             s2_load;
  logic             in_ready;
  logic             in_hs;
  op_e              in_op;
  logic [WIDTH-1:0] acc_src;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] acc_res;
  logic [WIDTH-1:0] s1_res;

  always_comb begin
    s2_load  = !s2_valid_q || bus.out_ready;
    in_ready = rst_n && (!s1_valid_q || s2_load);
    in_hs    = bus.in_valid && in_ready;
    in_op    = op_e'(bus.op);
    // A same-cycle clear makes the accumulate operand start from the reset value.
    acc_src  = bus.acc_clr ? ACC_RESET : accum_q;
    a_eff    = bus.acc_en ? acc_src : bus.A;
    acc_res  = logic_op(in_op, acc_src, bus.B);
    s1_res   = logic_op(s1_op_q, s1_a_q, s1_b_q);
  end

  // Stage 1 next state: load on accept, drain when S2 takes the entry.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = a_eff;
      s1_b_d     = bus.B;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: result and flags hold until consumed.
  always_comb begin
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    zero_d     = zero_q;
    all_ones_d = all_ones_q;
    parity_d   = parity_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        c_d        = s1_res;
        zero_d     = (s1_res == '0);
        all_ones_d = (s1_res == '1);
        parity_d   = ^s1_res;
      end
    end
  end

  always_comb begin
    accum_d = accum_q;
    if (in_hs && bus.acc_en) begin
      accum_d = acc_res;
    end else if (bus.acc_clr) begin
      accum_d = ACC_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpBuf;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      zero_q     <= 1'b0;
      all_ones_q <= 1'b0;
      parity_q   <= 1'b0;
      accum_q    <= ACC_RESET;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
      zero_q     <= zero_d;
      all_ones_q <= all_ones_d;
      parity_q   <= parity_d;
      accum_q    <= accum_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.C         = c_q;
  assign bus.zero      = zero_q;
  assign bus.all_ones  = all_ones_q;
  assign bus.parity    = parity_q;
  assign bus.acc_q     = accum_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH 8, 1 and 64 with hand-computed expectations.
module tb_logic_unit_pipe;

  localparam logic [2:0] OpBuf  = 3'd0;
  localparam logic [2:0] OpNot  = 3'd1;
  localparam logic [2:0] OpAnd  = 3'd2;
  localparam logic [2:0] OpOr   = 3'd3;
  localparam logic [2:0] OpXor  = 3'd4;
  localparam logic [63:0] Acc64 = 64'hA5A5_0000_FFFF_1234;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(8))  b8 ();
  logic_unit_pipe_if #(.WIDTH(1))  b1 ();
  logic_unit_pipe_if #(.WIDTH(64)) b64 ();

  logic_unit_pipe #(.WIDTH(8), .ACC_RESET(8'h00)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b8)
  );
  logic_unit_pipe #(.WIDTH(1), .ACC_RESET(1'b0)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );
  logic_unit_pipe #(.WIDTH(64), .ACC_RESET(Acc64)) u_dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic       clr;
    logic [7:0] c;
  } vec_t;

  vec_t vq[$];

  task automatic add8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic en, input logic clr, input logic [7:0] c);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.en = en; v.clr = clr; v.c = c;
    vq.push_back(v);
  endtask

  // Streams the queued vectors back-to-back; result j must appear two edges after its accept.
  task automatic run8(input string tag);
    int n;
    logic [7:0] e;
    n = vq.size();
    b8.out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        b8.in_valid = 1'b1;
        b8.op       = vq[i].op;
        b8.A        = vq[i].a;
        b8.B        = vq[i].b;
        b8.acc_en   = vq[i].en;
        b8.acc_clr  = vq[i].clr;
      end else begin
        b8.in_valid = 1'b0;
        b8.acc_en   = 1'b0;
        b8.acc_clr  = 1'b0;
      end
      #1;
      if (i < n) check_eq($sformatf("%s[%0d] in_ready", tag, i), 64'(b8.in_ready), 64'd1);
      @(posedge clk);
      #1;
      if (i >= 1) begin
        e = vq[i-1].c;
        check_eq($sformatf("%s[%0d] out_valid", tag, i-1), 64'(b8.out_valid), 64'd1);
        check_eq($sformatf("%s[%0d] C", tag, i-1), 64'(b8.C), 64'(e));
        check_eq($sformatf("%s[%0d] zero", tag, i-1), 64'(b8.zero), 64'(e == 8'h00));
        check_eq($sformatf("%s[%0d] all_ones", tag, i-1), 64'(b8.all_ones), 64'(e == 8'hFF));
        check_eq($sformatf("%s[%0d] parity", tag, i-1), 64'(b8.parity), 64'(^e));
      end
    end
    @(posedge clk);
    #1;
    vq.delete();
  endtask

  logic [7:0] exp_ops[8] = '{8'hF0, 8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};
  // Truth tables for ops 2..7, bit index {a,b}
  logic [3:0] tt[6] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};

  initial begin
    int   nxt;
    logic acc;
    int   got[$];
    logic [1:0] ab;
    logic e1;

    {b8.in_valid, b8.op, b8.acc_en, b8.acc_clr, b8.A, b8.B, b8.out_ready} = '0;
    {b1.in_valid, b1.op, b1.acc_en, b1.acc_clr, b1.A, b1.B, b1.out_ready} = '0;
    {b64.in_valid, b64.op, b64.acc_en, b64.acc_clr, b64.A, b64.B, b64.out_ready} = '0;
    rst_n = 1'b0;
    b8.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst in_ready", 64'(b8.in_ready), 64'd0);
    check_eq("rst out_valid", 64'(b8.out_valid), 64'd0);
    check_eq("rst C", 64'(b8.C), 64'd0);
    check_eq("rst zero", 64'(b8.zero), 64'd0);
    check_eq("rst all_ones", 64'(b8.all_ones), 64'd0);
    check_eq("rst parity", 64'(b8.parity), 64'd0);
    check_eq("rst acc_q", 64'(b8.acc_q), 64'd0);
    check_eq("rst acc_q w64", b64.acc_q, Acc64);
    check_eq("rst out_valid w1", 64'(b1.out_valid), 64'd0);
    b8.in_valid = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) add8(3'(k), 8'hF0, 8'hCC, 1'b0, 1'b0, exp_ops[k]);
    run8("ops");

    add8(OpAnd, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF);
    add8(OpXor, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00);
    run8("flags8");

    // Accumulator
    add8(OpOr, 8'h00, 8'h55, 1'b1, 1'b0, 8'h55);
    run8("acc_pre");
    check_eq("acc_pre acc_q", 64'(b8.acc_q), 64'h55);
    b8.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    b8.acc_clr = 1'b0;
    check_eq("acc_clr acc_q", 64'(b8.acc_q), 64'h00);
    add8(OpXor, 8'h00, 8'h01, 1'b1, 1'b0, 8'h01);
    add8(OpXor, 8'h00, 8'h02, 1'b1, 1'b0, 8'h03);
    add8(OpXor, 8'h00, 8'h04, 1'b1, 1'b0, 8'h07);
    add8(OpXor, 8'h00, 8'h08, 1'b1, 1'b0, 8'h0F);
    run8("acc_xor");
    check_eq("acc_xor acc_q", 64'(b8.acc_q), 64'h0F);
    add8(OpAnd, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'h0F);
    run8("acc_off");
    check_eq("acc_off acc_q", 64'(b8.acc_q), 64'h0F);
    add8(OpNot, 8'h00, 8'hAA, 1'b1, 1'b0, 8'hF0);
    add8(OpBuf, 8'h00, 8'h12, 1'b1, 1'b0, 8'hF0);
    add8(OpXor, 8'h77, 8'h30, 1'b1, 1'b1, 8'h30);
    run8("acc_mix");
    check_eq("acc_mix acc_q", 64'(b8.acc_q), 64'h30);

    // Backpressure: two accepts with out_ready low, then drain in order
    b8.op = OpOr; b8.A = 8'h00; b8.acc_en = 1'b0; b8.acc_clr = 1'b0;
    nxt = 1;
    for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
      b8.out_ready = (cyc >= 5);
      b8.in_valid  = (nxt <= 5);
      b8.B         = nxt[7:0];
      #1;
      if (cyc == 4) begin
        check_eq("bp accepted", 64'(nxt - 1), 64'd2);
        check_eq("bp in_ready", 64'(b8.in_ready), 64'd0);
        check_eq("bp out_valid", 64'(b8.out_valid), 64'd1);
        check_eq("bp C held", 64'(b8.C), 64'd1);
      end
      acc = b8.in_valid && b8.in_ready;
      if (b8.out_valid && b8.out_ready) got.push_back(int'(b8.C));
      @(posedge clk);
      #1;
      if (acc) nxt++;
    end
    b8.in_valid = 1'b0;
    check_eq("bp count", 64'(got.size()), 64'd5);
    for (int k = 0; k < got.size(); k++) check_eq($sformatf("bp order[%0d]", k), 64'(got[k]), 64'(k + 1));
    check_eq("bp drained", 64'(b8.out_valid), 64'd0);

    // Reset mid-stream
    b8.out_ready = 1'b1;
    b8.op = OpXor; b8.acc_en = 1'b1; b8.in_valid = 1'b1;
    b8.B = 8'h11; @(posedge clk); #1;
    b8.B = 8'h22; @(posedge clk); #1;
    b8.B = 8'h44; @(posedge clk); #1;
    check_eq("mid acc_q", 64'(b8.acc_q), 64'h47);
    b8.B = 8'h88;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid rst in_ready", 64'(b8.in_ready), 64'd0);
    rst_n = 1'b1;
    b8.in_valid = 1'b0; b8.acc_en = 1'b0;
    check_eq("mid rst out_valid", 64'(b8.out_valid), 64'd0);
    check_eq("mid rst C", 64'(b8.C), 64'd0);
    check_eq("mid rst zero", 64'(b8.zero), 64'd0);
    check_eq("mid rst acc_q", 64'(b8.acc_q), 64'd0);
    add8(OpAnd, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30);
    run8("post_rst");
    check_eq("post_rst acc_q", 64'(b8.acc_q), 64'd0);

    // WIDTH=1 truth tables
    b1.out_ready = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      if (i < 24) begin
        ab = 2'(i % 4);
        b1.in_valid = 1'b1;
        b1.op = 3'(2 + i / 4);
        b1.A  = ab[1];
        b1.B  = ab[0];
      end else begin
        b1.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        e1 = tt[(i-1) / 4][(i-1) % 4];
        check_eq($sformatf("w1 op%0d ab%0d C", 2 + (i-1) / 4, (i-1) % 4), 64'(b1.C), 64'(e1));
        check_eq($sformatf("w1 op%0d ab%0d zero", 2 + (i-1) / 4, (i-1) % 4), 64'(b1.zero), 64'(!e1));
        check_eq($sformatf("w1 op%0d ab%0d parity", 2 + (i-1) / 4, (i-1) % 4), 64'(b1.parity), 64'(e1));
        check_eq($sformatf("w1 op%0d ab%0d valid", 2 + (i-1) / 4, (i-1) % 4), 64'(b1.out_valid), 64'd1);
      end
    end

    // WIDTH=64 boundary flags
    b64.out_ready = 1'b1;
    b64.A = '1; b64.B = '1;
    b64.in_valid = 1'b1; b64.op = OpAnd;
    @(posedge clk); #1;
    b64.op = OpXor;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    check_eq("w64 and C", b64.C, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("w64 and all_ones", 64'(b64.all_ones), 64'd1);
    check_eq("w64 and zero", 64'(b64.zero), 64'd0);
    check_eq("w64 and parity", 64'(b64.parity), 64'd0);
    @(posedge clk); #1;
    check_eq("w64 xor valid", 64'(b64.out_valid), 64'd1);
    check_eq("w64 xor C", b64.C, 64'd0);
    check_eq("w64 xor zero", 64'(b64.zero), 64'd1);
    check_eq("w64 xor all_ones", 64'(b64.all_ones), 64'd0);
    check_eq("w64 xor parity", 64'(b64.parity), 64'd0);
    check_eq("w64 acc_q kept", b64.acc_q, Acc64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
